// File: rtl/norm_pkg.sv
// Shared types for the shift normalizer: operation modes and FSM states.
// The decode stage uses norm_mode_t to select Zbb clz/ctz.
package norm_pkg;

    typedef enum logic [1:0] {
        NORM_CLZ  = 2'd0,
        NORM_CTZ  = 2'd1,
        NORM_CLS  = 2'd2,
        NORM_PASS = 2'd3
    } norm_mode_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } norm_state_t;

endpackage

// File: rtl/shift_normalizer.sv
// Multi-cycle normalizer: one-bit-per-cycle CLZ / CTZ / CLS / PASS.
// Ports: clk, reset (sync, active-high); start/val/mode request;
//        ready, done handshake; norm_val and count results (registered).
module shift_normalizer
    import norm_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [WIDTH-1:0]         val,
    input  logic [1:0]               mode,
    output logic                     ready,
    output logic                     done,
    output logic [WIDTH-1:0]         norm_val,
    output logic [$clog2(WIDTH):0]   count
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] CNT_W  = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_W1 = CW'(WIDTH - 1);

    norm_state_t      r_state;
    norm_state_t      w_next;
    norm_mode_t       r_mode;
    logic [WIDTH-1:0] r_work;
    logic [CW-1:0]    r_cnt;

    logic             w_accept;
    logic             w_stop;
    logic [WIDTH-1:0] w_step;

    assign w_accept = start && (r_state == S_IDLE || r_state == S_DONE);

    // Stop test for the current working value and count.
    always_comb begin
        w_stop = 1'b1;
        case (r_mode)
            NORM_CLZ:  w_stop = r_work[WIDTH-1] || (r_cnt == CNT_W);
            NORM_CTZ:  w_stop = r_work[0] || (r_cnt == CNT_W);
            NORM_CLS:  w_stop = (r_work[WIDTH-1] != r_work[WIDTH-2])
                             || (r_cnt == CNT_W1);
            default:   w_stop = 1'b1;
        endcase
    end

    // One-bit step: CTZ moves right, the other modes move left.
    assign w_step = (r_mode == NORM_CTZ) ? (r_work >> 1) : (r_work << 1);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = start ? S_SHIFT : S_IDLE;
            S_SHIFT: w_next = w_stop ? S_DONE : S_SHIFT;
            S_DONE:  w_next = start ? S_SHIFT : S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Output logic.
    always_comb begin
        ready = 1'b0;
        done  = 1'b0;
        case (r_state)
            S_IDLE:  ready = 1'b1;
            S_DONE:  begin
                ready = 1'b1;
                done  = 1'b1;
            end
            default: ready = 1'b0;
        endcase
    end

    // Working register doubles as the result register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_work <= '0;
            r_cnt  <= '0;
            r_mode <= NORM_CLZ;
        end else if (w_accept) begin
            r_work <= val;
            r_cnt  <= '0;
            r_mode <= norm_mode_t'(mode);
        end else if (r_state == S_SHIFT && !w_stop) begin
            r_work <= w_step;
            r_cnt  <= r_cnt + 1'b1;
        end
    end

    assign norm_val = r_work;
    assign count    = r_cnt;

endmodule

// File: tb/tb_shift_normalizer.sv
// Directed bench for shift_normalizer (WIDTH=32).
// Table-driven single operations plus busy/back-to-back/reset sequences.
module tb_shift_normalizer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] val;
    logic [1:0]  mode;
    logic        ready;
    logic        done;
    logic [31:0] norm_val;
    logic [5:0]  count;

    int total = 0;
    int bad   = 0;

    shift_normalizer #(.WIDTH(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .val      (val),
        .mode     (mode),
        .ready    (ready),
        .done     (done),
        .norm_val (norm_val),
        .count    (count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  m;
        logic [31:0] v;
        logic [5:0]  c;
        logic [31:0] n;
    } vec_t;

    vec_t tv[13];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called just after the accepting edge; counts edges until done.
    task automatic wait_done(output int lat, output bit rdy_low);
        lat = 999;
        rdy_low = 1'b1;
        for (int i = 1; i <= 100; i++) begin
            if (ready !== 1'b0 || done !== 1'b0) rdy_low = 1'b0;
            tick();
            if (done === 1'b1) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic run_op(input logic [1:0] m, input logic [31:0] v,
                          output int lat, output bit rdy_low);
        start = 1'b1;
        val   = v;
        mode  = m;
        tick();
        start = 1'b0;
        val   = ~v;
        mode  = m + 2'd1;
        wait_done(lat, rdy_low);
    endtask

    int lat;
    int lat2;
    bit rl;
    bit seen;

    initial begin
        tv[0]  = '{2'd0, 32'h0001_0000, 6'd15, 32'h8000_0000};
        tv[1]  = '{2'd1, 32'h0000_0028, 6'd3,  32'h0000_0005};
        tv[2]  = '{2'd3, 32'd21,        6'd0,  32'd21};
        tv[3]  = '{2'd2, 32'hFFFF_FFEB, 6'd26, 32'hAC00_0000};
        tv[4]  = '{2'd2, 32'h0000_0000, 6'd31, 32'h0000_0000};
        tv[5]  = '{2'd0, 32'h0000_0000, 6'd32, 32'h0000_0000};
        tv[6]  = '{2'd1, 32'h0000_0000, 6'd32, 32'h0000_0000};
        tv[7]  = '{2'd2, 32'hFFFF_FFFF, 6'd31, 32'h8000_0000};
        tv[8]  = '{2'd0, 32'h8000_0000, 6'd0,  32'h8000_0000};
        tv[9]  = '{2'd1, 32'h8000_0000, 6'd31, 32'h0000_0001};
        tv[10] = '{2'd2, 32'h4000_0000, 6'd0,  32'h4000_0000};
        tv[11] = '{2'd0, 32'h0000_0001, 6'd31, 32'h8000_0000};
        tv[12] = '{2'd3, 32'h0000_0000, 6'd0,  32'h0000_0000};

        reset = 1'b1;
        start = 1'b0;
        val   = '0;
        mode  = '0;
        tick();
        tick();
        chk("rst_ready", 64'(ready), 64'd1);
        chk("rst_done",  64'(done),  64'd0);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_norm",  64'(norm_val), 64'd0);
        reset = 1'b0;
        tick();

        for (int k = 0; k < 13; k++) begin
            run_op(tv[k].m, tv[k].v, lat, rl);
            chk($sformatf("v%0d_count", k), 64'(count), 64'(tv[k].c));
            chk($sformatf("v%0d_norm", k), 64'(norm_val), 64'(tv[k].n));
            chk($sformatf("v%0d_lat", k), 64'(lat), 64'(tv[k].c) + 64'd1);
            chk($sformatf("v%0d_busy", k), 64'(rl), 64'd1);
            chk($sformatf("v%0d_rdy", k), 64'(ready), 64'd1);
            tick();
            chk($sformatf("v%0d_pulse", k), 64'(done), 64'd0);
        end

        // Results hold in IDLE.
        repeat (3) tick();
        chk("hold_count", 64'(count), 64'd0);
        chk("hold_norm",  64'(norm_val), 64'd0);

        // Start while busy is ignored.
        start = 1'b1;
        val   = 32'h0001_0000;
        mode  = 2'd0;
        tick();
        start = 1'b0;
        repeat (3) tick();
        start = 1'b1;
        val   = 32'hFFFF_FFFF;
        mode  = 2'd1;
        tick();
        start = 1'b0;
        wait_done(lat, rl);
        chk("busy_count", 64'(count), 64'd15);
        chk("busy_norm",  64'(norm_val), 64'h8000_0000);
        chk("busy_lat",   64'(lat + 4), 64'd16);

        // Back-to-back: start held during the DONE cycle.
        start = 1'b1;
        val   = 32'h0000_0028;
        mode  = 2'd1;
        tick();
        start = 1'b0;
        chk("b2b_ready", 64'(ready), 64'd0);
        chk("b2b_done",  64'(done),  64'd0);
        chk("b2b_clr",   64'(count), 64'd0);
        chk("b2b_cap",   64'(norm_val), 64'h0000_0028);
        wait_done(lat2, rl);
        chk("b2b_count", 64'(count), 64'd3);
        chk("b2b_norm",  64'(norm_val), 64'h0000_0005);
        chk("b2b_lat",   64'(lat2), 64'd4);
        tick();

        // Reset mid-operation aborts.
        start = 1'b1;
        val   = 32'h0000_0001;
        mode  = 2'd0;
        tick();
        start = 1'b0;
        repeat (4) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort_ready", 64'(ready), 64'd1);
        chk("abort_done",  64'(done),  64'd0);
        chk("abort_count", 64'(count), 64'd0);
        chk("abort_norm",  64'(norm_val), 64'd0);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done === 1'b1) seen = 1'b1;
        end
        chk("abort_nodone", 64'(seen), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
